rx_frame_ctrl: RTL and testbench

//  Receive-side controller between frame_decode and the PICC protocol layer.
//  - Gates frame_decode events with rx_enable and tracks each PCD frame through an FSM.
//  - Forwards decoded bytes, counts them and latches error flags.
//  - Emits a one-cycle rx_done with a stable status word, so the protocol layer never handles raw soc/eoc/error pulses.

---
 rtl/rx_frame_ctrl.sv | 178 +++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module : rx_frame_ctrl
// Brief  : Receive-side frame controller between frame_decode and PICC layer.
// Rev    : 1.0  initial release
// ============================================================================
module rx_frame_ctrl #(
  parameter int MAX_BYTES = 64,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_enable,
  input  logic             soc,
  input  logic             eoc,
  input  logic [7:0]       data,
  input  logic [2:0]       data_bits,
  input  logic             data_valid,
  input  logic             sequence_error,
  input  logic             parity_error,
  output logic [7:0]       rx_byte,
  output logic [2:0]       rx_byte_bits,
  output logic             rx_byte_valid,
  output logic             rx_busy,
  output logic             rx_done,
  output logic [CNT_W-1:0] rx_len,
  output logic [2:0]       rx_last_bits,
  output logic             rx_short,
  output logic             rx_err_seq,
  output logic             rx_err_par,
  output logic             rx_err_ovf
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACTIVE   = 2'd1,
    S_ERR_WAIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         rx_byte_q, rx_byte_d;
  logic [2:0]         rx_byte_bits_q, rx_byte_bits_d;
  logic               rx_byte_valid_q, rx_byte_valid_d;
  logic               rx_busy_q, rx_busy_d;
  logic               rx_done_q, rx_done_d;
  logic [CNT_W-1:0]   rx_len_q, rx_len_d;
  logic [2:0]         rx_last_bits_q, rx_last_bits_d;
  logic               rx_short_q, rx_short_d;
  logic               rx_err_seq_q, rx_err_seq_d;
  logic               rx_err_par_q, rx_err_par_d;
  logic               rx_err_ovf_q, rx_err_ovf_d;

  always_comb begin
    state_d         = state_q;
    rx_byte_d       = rx_byte_q;
    rx_byte_bits_d  = rx_byte_bits_q;
    rx_byte_valid_d = 1'b0;
    rx_done_d       = 1'b0;
    rx_len_d        = rx_len_q;
    rx_last_bits_d  = rx_last_bits_q;
    rx_short_d      = rx_short_q;
    rx_err_seq_d    = rx_err_seq_q;
    rx_err_par_d    = rx_err_par_q;
    rx_err_ovf_d    = rx_err_ovf_q;

    case (state_q)
      S_IDLE: begin
        if (soc && rx_enable) begin
          state_d        = S_ACTIVE;
          rx_len_d       = '0;
          rx_last_bits_d = 3'd0;
          rx_short_d     = 1'b0;
          rx_err_seq_d   = 1'b0;
          rx_err_par_d   = 1'b0;
          rx_err_ovf_d   = 1'b0;
        end
      end
      default: begin
        // A new soc mid-frame aborts silently; it restarts only if enabled.
        if (soc) begin
          if (rx_enable) begin
            state_d        = S_ACTIVE;
            rx_len_d       = '0;
            rx_last_bits_d = 3'd0;
            rx_short_d     = 1'b0;
            rx_err_seq_d   = 1'b0;
            rx_err_par_d   = 1'b0;
            rx_err_ovf_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (!rx_enable) begin
          state_d = S_IDLE;
        end else begin
          if (sequence_error || parity_error) begin
            rx_err_seq_d = rx_err_seq_q | sequence_error;
            rx_err_par_d = rx_err_par_q | parity_error;
            state_d      = S_ERR_WAIT;
          end else if (data_valid && (state_q == S_ACTIVE)) begin
            if (data_bits == 3'd0) begin
              if (rx_len_q < CNT_W'(MAX_BYTES)) begin
                rx_byte_d       = data;
                rx_byte_bits_d  = data_bits;
                rx_byte_valid_d = 1'b1;
                rx_len_d        = rx_len_q + CNT_W'(1);
              end else begin
                rx_err_ovf_d = 1'b1;
              end
            end else begin
              rx_byte_d       = data;
              rx_byte_bits_d  = data_bits;
              rx_byte_valid_d = 1'b1;
              rx_last_bits_d  = data_bits;
            end
          end

          // Same-cycle data/errors above are already folded into the _d status.
          if (eoc) begin
            state_d   = S_IDLE;
            rx_done_d = 1'b1;
            if ((rx_len_d == '0) && (rx_last_bits_d == 3'd0) &&
                !rx_err_seq_d && !rx_err_par_d && !rx_err_ovf_d) begin
              rx_err_seq_d = 1'b1;
            end
            rx_short_d = (rx_len_d == '0) && (rx_last_bits_d == 3'd7) &&
                         !(rx_err_seq_d || rx_err_par_d || rx_err_ovf_d);
          end
        end
      end
    endcase

    rx_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      rx_byte_q       <= 8'h00;
      rx_byte_bits_q  <= 3'd0;
      rx_byte_valid_q <= 1'b0;
      rx_busy_q       <= 1'b0;
      rx_done_q       <= 1'b0;
      rx_len_q        <= '0;
      rx_last_bits_q  <= 3'd0;
      rx_short_q      <= 1'b0;
      rx_err_seq_q    <= 1'b0;
      rx_err_par_q    <= 1'b0;
      rx_err_ovf_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      rx_byte_q       <= rx_byte_d;
      rx_byte_bits_q  <= rx_byte_bits_d;
      rx_byte_valid_q <= rx_byte_valid_d;
      rx_busy_q       <= rx_busy_d;
      rx_done_q       <= rx_done_d;
      rx_len_q        <= rx_len_d;
      rx_last_bits_q  <= rx_last_bits_d;
      rx_short_q      <= rx_short_d;
      rx_err_seq_q    <= rx_err_seq_d;
      rx_err_par_q    <= rx_err_par_d;
      rx_err_ovf_q    <= rx_err_ovf_d;
    end
  end

  assign rx_byte       = rx_byte_q;
  assign rx_byte_bits  = rx_byte_bits_q;
  assign rx_byte_valid = rx_byte_valid_q;
  assign rx_busy       = rx_busy_q;
  assign rx_done       = rx_done_q;
  assign rx_len        = rx_len_q;
  assign rx_last_bits  = rx_last_bits_q;
  assign rx_short      = rx_short_q;
  assign rx_err_seq    = rx_err_seq_q;
  assign rx_err_par    = rx_err_par_q;
  assign rx_err_ovf    = rx_err_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_rx_frame_ctrl
// Brief  : Directed self-checking bench for rx_frame_ctrl (MAX_BYTES = 4).
// Rev    : 1.0  initial release
// ============================================================================
module tb_rx_frame_ctrl;

  localparam int MAX_BYTES = 4;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);

  logic             clk;
  logic             rst_n;
  logic             rx_enable;
  logic             soc;
  logic             eoc;
  logic [7:0]       data;
  logic [2:0]       data_bits;
  logic             data_valid;
  logic             sequence_error;
  logic             parity_error;
  logic [7:0]       rx_byte;
  logic [2:0]       rx_byte_bits;
  logic             rx_byte_valid;
  logic             rx_busy;
  logic             rx_done;
  logic [CNT_W-1:0] rx_len;
  logic [2:0]       rx_last_bits;
  logic             rx_short;
  logic             rx_err_seq;
  logic             rx_err_par;
  logic             rx_err_ovf;

  int n_cmp;
  int n_bad;

  rx_frame_ctrl #(.MAX_BYTES(MAX_BYTES)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_enable      (rx_enable),
    .soc            (soc),
    .eoc            (eoc),
    .data           (data),
    .data_bits      (data_bits),
    .data_valid     (data_valid),
    .sequence_error (sequence_error),
    .parity_error   (parity_error),
    .rx_byte        (rx_byte),
    .rx_byte_bits   (rx_byte_bits),
    .rx_byte_valid  (rx_byte_valid),
    .rx_busy        (rx_busy),
    .rx_done        (rx_done),
    .rx_len         (rx_len),
    .rx_last_bits   (rx_last_bits),
    .rx_short       (rx_short),
    .rx_err_seq     (rx_err_seq),
    .rx_err_par     (rx_err_par),
    .rx_err_ovf     (rx_err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic done, input logic [CNT_W-1:0] len,
                            input logic [2:0] last, input logic shrt, input logic seq,
                            input logic par, input logic ovf);
    chk({tag, ".done"},  8'(rx_done),      8'(done));
    chk({tag, ".len"},   8'(rx_len),       8'(len));
    chk({tag, ".last"},  8'(rx_last_bits), 8'(last));
    chk({tag, ".short"}, 8'(rx_short),     8'(shrt));
    chk({tag, ".seq"},   8'(rx_err_seq),   8'(seq));
    chk({tag, ".par"},   8'(rx_err_par),   8'(par));
    chk({tag, ".ovf"},   8'(rx_err_ovf),   8'(ovf));
  endtask

  task automatic pulse_soc();
    soc = 1'b1;
    cyc();
    soc = 1'b0;
  endtask

  task automatic pulse_eoc();
    eoc = 1'b1;
    cyc();
    eoc = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic [2:0] bits);
    data = b; data_bits = bits; data_valid = 1'b1;
    cyc();
    data_valid = 1'b0;
  endtask

  task automatic chk_fwd(input string tag, input logic [7:0] b, input logic [2:0] bits);
    chk({tag, ".valid"}, 8'(rx_byte_valid), 8'h01);
    chk({tag, ".byte"},  rx_byte,           b);
    chk({tag, ".bits"},  8'(rx_byte_bits),  8'(bits));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; rx_enable = 1'b0; soc = 1'b0; eoc = 1'b0;
    data = 8'h00; data_bits = 3'd0; data_valid = 1'b0;
    sequence_error = 1'b0; parity_error = 1'b0;
    cyc(); cyc();

    // Reset state
    chk("rst.byte",  rx_byte, 8'h00);
    chk("rst.bits",  8'(rx_byte_bits), 8'h00);
    chk("rst.valid", 8'(rx_byte_valid), 8'h00);
    chk("rst.busy",  8'(rx_busy), 8'h00);
    chk_status("rst", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; rx_enable = 1'b1;
    cyc();

    // 1: two full bytes
    pulse_soc();
    chk("t1.busy", 8'(rx_busy), 8'h01);
    send(8'hA5, 3'd0); chk_fwd("t1.b0", 8'hA5, 3'd0);
    send(8'h3C, 3'd0); chk_fwd("t1.b1", 8'h3C, 3'd0);
    chk("t1.nodone", 8'(rx_done), 8'h00);
    pulse_eoc();
    chk_status("t1", 1'b1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1.idle", 8'(rx_busy), 8'h00);
    chk("t1.nvalid", 8'(rx_byte_valid), 8'h00);
    cyc();
    chk("t1.donepulse", 8'(rx_done), 8'h00);
    chk("t1.hold", 8'(rx_len), 8'h02);

    // 2: 7-bit short frame with eoc in the same cycle as the data
    pulse_soc();
    chk("t2.clr", 8'(rx_len), 8'h00);
    data = 8'h26; data_bits = 3'd7; data_valid = 1'b1; eoc = 1'b1;
    cyc();
    data_valid = 1'b0; eoc = 1'b0;
    chk_fwd("t2.b", 8'h26, 3'd7);
    chk_status("t2", 1'b1, 3'd0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);

    // 3: parity error mid-frame; later byte is not forwarded
    pulse_soc();
    send(8'h11, 3'd0); chk_fwd("t3.b0", 8'h11, 3'd0);
    send(8'h22, 3'd0); chk_fwd("t3.b1", 8'h22, 3'd0);
    parity_error = 1'b1; cyc(); parity_error = 1'b0;
    chk("t3.busy", 8'(rx_busy), 8'h01);
    send(8'h33, 3'd0);
    chk("t3.drop", 8'(rx_byte_valid), 8'h00);
    pulse_eoc();
    chk_status("t3", 1'b1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 4: overflow, 6 bytes into MAX_BYTES=4
    pulse_soc();
    for (int i = 0; i < 6; i++) begin
      send(8'(8'h40 + i), 3'd0);
      chk($sformatf("t4.v%0d", i), 8'(rx_byte_valid), (i < 4) ? 8'h01 : 8'h00);
    end
    chk("t4.lastfwd", rx_byte, 8'h43);
    pulse_eoc();
    chk_status("t4", 1'b1, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    chk("t4.once", 8'(rx_done), 8'h00);

    // Empty frame: soc then eoc only
    pulse_soc();
    pulse_eoc();
    chk_status("empty", 1'b1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 5: rx_enable dropped mid-frame, then soc while disabled
    pulse_soc();
    send(8'h01, 3'd0);
    send(8'h02, 3'd0);
    rx_enable = 1'b0;
    cyc();
    chk("t5.busy", 8'(rx_busy), 8'h00);
    chk("t5.partial", 8'(rx_len), 8'h02);
    pulse_eoc();
    chk("t5.nodone", 8'(rx_done), 8'h00);
    pulse_soc();
    chk("t5.ign", 8'(rx_busy), 8'h00);
    chk("t5.nclr", 8'(rx_len), 8'h02);
    rx_enable = 1'b1;
    cyc();

    // 6: soc restart mid-frame, then reset mid-frame
    pulse_soc();
    send(8'h99, 3'd0);
    pulse_soc();
    chk("t6.busy", 8'(rx_busy), 8'h01);
    chk("t6.nodone", 8'(rx_done), 8'h00);
    chk("t6.clr", 8'(rx_len), 8'h00);
    send(8'h5A, 3'd0); chk_fwd("t6.b", 8'h5A, 3'd0);
    pulse_eoc();
    chk_status("t6", 1'b1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("t6.once", 8'(rx_done), 8'h00);
    pulse_soc();
    send(8'h77, 3'd0); chk_fwd("t6r.b", 8'h77, 3'd0);
    rst_n = 1'b0;
    data = 8'h88; data_bits = 3'd0; data_valid = 1'b1;
    cyc();
    data_valid = 1'b0;
    chk("t6r.byte",  rx_byte, 8'h00);
    chk("t6r.valid", 8'(rx_byte_valid), 8'h00);
    chk("t6r.busy",  8'(rx_busy), 8'h00);
    chk_status("t6r", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
